// File: rtl/wb_daq_sample_writer.sv
// Write-DMA stage: buffers acquisition samples in a small FIFO and stores them
// as consecutive 32-bit words through a classic Wishbone B3 master port.
module wb_daq_sample_writer #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst,
  input  logic                 start,
  input  logic [31:0]          base_adr,
  input  logic [CNT_WIDTH-1:0] num_samples,
  input  logic [31:0]          sample_dat,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic [31:0]          wb_master_adr_o,
  output logic [31:0]          wb_master_dat_o,
  output logic [3:0]           wb_master_sel_o,
  output logic                 wb_master_we_o,
  output logic                 wb_master_cyc_o,
  output logic                 wb_master_stb_o,
  output logic [2:0]           wb_master_cti_o,
  output logic [1:0]           wb_master_bte_o,
  input  logic                 wb_master_ack_i,
  input  logic                 wb_master_err_i,
  input  logic                 wb_master_rty_i,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [CNT_WIDTH-1:0] words_written
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_DATA = 3'd1,
    S_WRITE     = 3'd2,
    S_RETRY     = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t               state_q;
  logic [31:0]          adr_q;
  logic [31:0]          wb_adr_q;
  logic [31:0]          wb_dat_q;
  logic [3:0]           sel_q;
  logic                 cyc_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] accepted_q;
  logic [CNT_WIDTH-1:0] ww_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 error_q;

  logic [31:0]          mem_q [FIFO_DEPTH];
  logic [AW:0]          wr_ptr_q;
  logic [AW:0]          rd_ptr_q;
  logic [AW:0]          wr_ptr_d;
  logic [AW:0]          rd_ptr_d;
  logic [AW:0]          fifo_level;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [31:0]          fifo_head;
  logic                 push;
  logic                 pop;
  logic [31:0]          base_aligned;

  assign base_aligned = base_adr & 32'hFFFF_FFFC;
  assign fifo_level   = wr_ptr_q - rd_ptr_q;
  assign fifo_full    = (fifo_level == DEPTH_L);
  assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
  assign fifo_head    = mem_q[rd_ptr_q[AW-1:0]];

  // Samples beyond the programmed count are never accepted.
  assign sample_ready = busy_q && !fifo_full && (accepted_q < count_q);
  assign push         = sample_valid && sample_ready;
  assign pop          = (state_q == S_WRITE) && wb_master_ack_i && !wb_master_err_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= sample_dat;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst) begin
      state_q    <= S_IDLE;
      adr_q      <= 32'h0000_0000;
      wb_adr_q   <= 32'h0000_0000;
      wb_dat_q   <= 32'h0000_0000;
      sel_q      <= 4'h0;
      cyc_q      <= 1'b0;
      count_q    <= {CNT_WIDTH{1'b0}};
      accepted_q <= {CNT_WIDTH{1'b0}};
      ww_q       <= {CNT_WIDTH{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      wr_ptr_q   <= {(AW+1){1'b0}};
      rd_ptr_q   <= {(AW+1){1'b0}};
    end else begin
      done_q   <= 1'b0;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) begin
        accepted_q <= accepted_q + CNT_WIDTH'(1);
      end
      case (state_q)
        S_IDLE: begin
          // busy stays high through the done cycle so a start there is ignored
          if (busy_q) begin
            busy_q <= 1'b0;
          end else if (start) begin
            adr_q      <= base_aligned;
            count_q    <= num_samples;
            ww_q       <= {CNT_WIDTH{1'b0}};
            accepted_q <= {CNT_WIDTH{1'b0}};
            error_q    <= 1'b0;
            busy_q     <= 1'b1;
            wr_ptr_q   <= {(AW+1){1'b0}};
            rd_ptr_q   <= {(AW+1){1'b0}};
            state_q    <= (num_samples == {CNT_WIDTH{1'b0}}) ? S_DONE : S_WAIT_DATA;
          end
        end
        S_WAIT_DATA: begin
          if (!fifo_empty) begin
            wb_adr_q <= adr_q;
            wb_dat_q <= fifo_head;
            cyc_q    <= 1'b1;
            sel_q    <= 4'hF;
            state_q  <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (wb_master_err_i) begin
            cyc_q    <= 1'b0;
            sel_q    <= 4'h0;
            error_q  <= 1'b1;
            busy_q   <= 1'b0;
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
            state_q  <= S_IDLE;
          end else if (wb_master_ack_i) begin
            cyc_q   <= 1'b0;
            sel_q   <= 4'h0;
            ww_q    <= ww_q + CNT_WIDTH'(1);
            adr_q   <= adr_q + 32'd4;
            state_q <= ((ww_q + CNT_WIDTH'(1)) == count_q) ? S_DONE : S_WAIT_DATA;
          end else if (wb_master_rty_i) begin
            cyc_q   <= 1'b0;
            sel_q   <= 4'h0;
            state_q <= S_RETRY;
          end
        end
        S_RETRY: begin
          cyc_q   <= 1'b1;
          sel_q   <= 4'hF;
          state_q <= S_WRITE;
        end
        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          cyc_q   <= 1'b0;
          sel_q   <= 4'h0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign wb_master_adr_o = wb_adr_q;
  assign wb_master_dat_o = wb_dat_q;
  assign wb_master_sel_o = sel_q;
  assign wb_master_we_o  = cyc_q;
  assign wb_master_cyc_o = cyc_q;
  assign wb_master_stb_o = cyc_q;
  assign wb_master_cti_o = 3'b000;
  assign wb_master_bte_o = 2'b00;
  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;
  assign words_written   = ww_q;

endmodule

// File: tb/tb_wb_daq_sample_writer.sv
// Table-driven bench for wb_daq_sample_writer: each record is one transfer run
// against a Wishbone slave model, followed by a hand-written mid-write reset.
module tb_wb_daq_sample_writer;

  logic        wb_clk;
  logic        wb_rst;
  logic        start;
  logic [31:0] base_adr;
  logic [15:0] num_samples;
  logic [31:0] sample_dat;
  logic        sample_valid;
  logic        sample_ready;
  logic [31:0] wb_master_adr_o;
  logic [31:0] wb_master_dat_o;
  logic [3:0]  wb_master_sel_o;
  logic        wb_master_we_o;
  logic        wb_master_cyc_o;
  logic        wb_master_stb_o;
  logic [2:0]  wb_master_cti_o;
  logic [1:0]  wb_master_bte_o;
  logic        wb_master_ack_i;
  logic        wb_master_err_i;
  logic        wb_master_rty_i;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_written;

  int n_chk  = 0;
  int n_pass = 0;

  wb_daq_sample_writer #(.FIFO_DEPTH(16), .CNT_WIDTH(16)) dut (
    .wb_clk          (wb_clk),
    .wb_rst          (wb_rst),
    .start           (start),
    .base_adr        (base_adr),
    .num_samples     (num_samples),
    .sample_dat      (sample_dat),
    .sample_valid    (sample_valid),
    .sample_ready    (sample_ready),
    .wb_master_adr_o (wb_master_adr_o),
    .wb_master_dat_o (wb_master_dat_o),
    .wb_master_sel_o (wb_master_sel_o),
    .wb_master_we_o  (wb_master_we_o),
    .wb_master_cyc_o (wb_master_cyc_o),
    .wb_master_stb_o (wb_master_stb_o),
    .wb_master_cti_o (wb_master_cti_o),
    .wb_master_bte_o (wb_master_bte_o),
    .wb_master_ack_i (wb_master_ack_i),
    .wb_master_err_i (wb_master_err_i),
    .wb_master_rty_i (wb_master_rty_i),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .words_written   (words_written)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  typedef struct {
    logic [31:0] base;
    logic [31:0] exp_base;
    logic [31:0] seed;
    int num;
    int ack_wait;    // cycles the first write is held without response
    int rty_at;      // 1-based write index answered once with rty (0 = none)
    int err_at;      // 1-based write index answered with err (0 = none)
    int mid_start;   // pulse a stray start while busy
    int done_start;  // pulse a start in the done cycle
    int fill_chk;    // samples expected accepted at first ack (-1 = skip)
    int exp_ww;
    int exp_done;
    int exp_err;
    int exp_lat;     // done cycle relative to start (0 = skip)
    int exp_acc;     // total samples accepted (-1 = skip)
  } vec_t;

  vec_t vecs [8];
  vec_t post_rst;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic run_xfer(input vec_t v, input int id);
    int c, acc, widx, first_hs, first_stb, done_cyc, done_cnt, end_c;
    int stb_wait, cur_wait, acc_at_ack, idle_rty, bus_bad, order_bad;
    bit any_cyc, last_rsp, rty_done, rty_pend, err_given, exp_any;
    logic [31:0] exp_adr, rty_adr, rty_dat;
    acc = 0; widx = 0; first_hs = -1; first_stb = -1; done_cyc = -1; done_cnt = 0;
    end_c = -1; stb_wait = 0; acc_at_ack = -1; idle_rty = 0; bus_bad = 0; order_bad = 0;
    any_cyc = 0; last_rsp = 0; rty_done = 0; rty_pend = 0; err_given = 0;
    exp_adr = v.exp_base; rty_adr = 32'h0; rty_dat = 32'h0;
    exp_any = (v.exp_ww > 0) || (v.exp_err != 0);

    start = 1'b1; base_adr = v.base; num_samples = 16'(v.num);
    @(posedge wb_clk); #1;
    start = 1'b0;
    c = 1;
    while (c < 600 && (end_c < 0 || c <= end_c)) begin
      // observe
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (wb_master_cyc_o) begin
        any_cyc = 1'b1;
        if (wb_master_sel_o !== 4'hF || wb_master_we_o !== 1'b1 || wb_master_stb_o !== 1'b1) bus_bad++;
      end else if (wb_master_sel_o !== 4'h0 || wb_master_we_o !== 1'b0 || wb_master_stb_o !== 1'b0) begin
        bus_bad++;
      end
      if (wb_master_cti_o !== 3'b000 || wb_master_bte_o !== 2'b00) bus_bad++;

      // stray starts that must be ignored
      start = 1'b0;
      if (v.mid_start != 0 && c == 4) begin
        start = 1'b1; base_adr = 32'hDEAD_0000; num_samples = 16'd1;
      end
      if (v.done_start != 0 && done) begin
        start = 1'b1; base_adr = 32'h0000_9000; num_samples = 16'd1;
      end

      // sample source: valid held high the whole time
      sample_valid = 1'b1;
      sample_dat   = v.seed + 32'(acc);
      if (sample_ready) begin
        if (first_hs < 0) first_hs = c;
        acc++;
      end

      // Wishbone slave
      wb_master_ack_i = 1'b0; wb_master_err_i = 1'b0; wb_master_rty_i = 1'b0;
      if (wb_master_stb_o) begin
        if (first_stb < 0) first_stb = c;
        if (last_rsp) bus_bad++;
        if (rty_pend) begin
          if (wb_master_adr_o !== rty_adr || wb_master_dat_o !== rty_dat || idle_rty != 1) bus_bad++;
          rty_pend = 1'b0;
        end
        cur_wait = (widx == 0) ? v.ack_wait : 0;
        if (stb_wait >= cur_wait) begin
          stb_wait = 0;
          last_rsp = 1'b1;
          if (widx + 1 == v.err_at) begin
            wb_master_err_i = 1'b1; err_given = 1'b1;
          end else if (widx + 1 == v.rty_at && !rty_done) begin
            wb_master_rty_i = 1'b1; rty_done = 1'b1; rty_pend = 1'b1; idle_rty = 0;
            rty_adr = wb_master_adr_o; rty_dat = wb_master_dat_o;
          end else begin
            wb_master_ack_i = 1'b1;
            if (widx == 0) acc_at_ack = acc;
            if (wb_master_adr_o !== exp_adr || wb_master_dat_o !== v.seed + 32'(widx)) order_bad++;
            exp_adr = exp_adr + 32'd4;
            widx++;
          end
        end else begin
          stb_wait++;
          last_rsp = 1'b0;
        end
      end else begin
        last_rsp = 1'b0;
        if (rty_pend) idle_rty++;
      end

      if (end_c < 0 && (done_cnt > 0 || err_given)) end_c = c + 4;
      @(posedge wb_clk); #1;
      c++;
    end
    wb_master_ack_i = 1'b0; wb_master_err_i = 1'b0; wb_master_rty_i = 1'b0;
    start = 1'b0; sample_valid = 1'b0;

    chk($sformatf("v%0d_timeout", id), 64'(end_c < 0), 64'd0);
    chk($sformatf("v%0d_done_pulses", id), 64'(done_cnt), 64'(v.exp_done));
    chk($sformatf("v%0d_error", id), 64'(error), 64'(v.exp_err));
    chk($sformatf("v%0d_busy_end", id), 64'(busy), 64'd0);
    chk($sformatf("v%0d_ready_end", id), 64'(sample_ready), 64'd0);
    chk($sformatf("v%0d_words_written", id), 64'(words_written), 64'(v.exp_ww));
    chk($sformatf("v%0d_acks", id), 64'(widx), 64'(v.exp_ww));
    chk($sformatf("v%0d_adr_dat_order", id), 64'(order_bad), 64'd0);
    chk($sformatf("v%0d_bus_protocol", id), 64'(bus_bad), 64'd0);
    chk($sformatf("v%0d_any_cyc", id), 64'(any_cyc), 64'(exp_any));
    if (v.exp_acc >= 0) chk($sformatf("v%0d_accepted", id), 64'(acc), 64'(v.exp_acc));
    if (v.exp_lat > 0) chk($sformatf("v%0d_done_latency", id), 64'(done_cyc), 64'(v.exp_lat));
    if (v.fill_chk >= 0) chk($sformatf("v%0d_fifo_fill", id), 64'(acc_at_ack), 64'(v.fill_chk));
    if (exp_any) chk($sformatf("v%0d_stb_latency", id), 64'(first_stb - first_hs), 64'd2);
  endtask

  initial begin
    wb_rst = 1'b0; start = 1'b0; base_adr = 32'h0; num_samples = 16'h0;
    sample_dat = 32'h0; sample_valid = 1'b0;
    wb_master_ack_i = 1'b0; wb_master_err_i = 1'b0; wb_master_rty_i = 1'b0;

    //              base          exp_base      seed   num wt rty err mid dst fill ww dn er lat acc
    vecs[0] = '{32'h0000_0100, 32'h0000_0100, 32'hA0,    4, 0, 0, 0, 0, 0, -1,  4, 1, 0, 0,  4};
    vecs[1] = '{32'h0000_0500, 32'h0000_0500, 32'h00,    0, 0, 0, 0, 0, 1, -1,  0, 1, 0, 2,  0};
    vecs[2] = '{32'h0000_2000, 32'h0000_2000, 32'h1000, 40,30, 0, 0, 0, 0, 16, 40, 1, 0, 0, 40};
    vecs[3] = '{32'h0000_3000, 32'h0000_3000, 32'h55,    5, 0, 2, 0, 0, 0, -1,  5, 1, 0, 0,  5};
    vecs[4] = '{32'h0000_4000, 32'h0000_4000, 32'h77,    8, 0, 0, 3, 0, 0, -1,  2, 0, 1, 0, -1};
    vecs[5] = '{32'h0000_5004, 32'h0000_5004, 32'h90,    3, 0, 0, 0, 1, 0, -1,  3, 1, 0, 0,  3};
    vecs[6] = '{32'hFFFF_FFFA, 32'hFFFF_FFF8, 32'hC0,    4, 0, 0, 0, 0, 0, -1,  4, 1, 0, 0,  4};
    vecs[7] = '{32'h0000_1003, 32'h0000_1000, 32'h11,    2, 0, 0, 0, 0, 0, -1,  2, 1, 0, 0,  2};
    post_rst = '{32'h0000_0700, 32'h0000_0700, 32'h33,   3, 0, 0, 0, 0, 0, -1,  3, 1, 0, 0,  3};

    repeat (2) @(posedge wb_clk);
    #1;
    chk("rst_cyc_stb_we", {61'd0, wb_master_cyc_o, wb_master_stb_o, wb_master_we_o}, 64'd0);
    chk("rst_sel", 64'(wb_master_sel_o), 64'd0);
    chk("rst_adr_dat", {wb_master_adr_o, wb_master_dat_o}, 64'd0);
    chk("rst_status", {60'd0, busy, done, error, sample_ready}, 64'd0);
    chk("rst_words_written", 64'(words_written), 64'd0);
    wb_rst = 1'b1;
    @(posedge wb_clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_xfer(vecs[i], i);
      repeat (2) @(posedge wb_clk);
      #1;
    end

    // reset held low for one cycle while a write is outstanding
    start = 1'b1; base_adr = 32'h0000_0600; num_samples = 16'd4;
    @(posedge wb_clk); #1;
    start = 1'b0; sample_valid = 1'b1; sample_dat = 32'h0000_BAD0;
    for (int k = 0; k < 20 && !wb_master_stb_o; k++) begin
      @(posedge wb_clk); #1;
    end
    chk("rstmid_stb_seen", 64'(wb_master_stb_o), 64'd1);
    wb_rst = 1'b0; sample_valid = 1'b0;
    @(posedge wb_clk); #1;
    chk("rstmid_cyc_stb", {62'd0, wb_master_cyc_o, wb_master_stb_o}, 64'd0);
    chk("rstmid_status", {60'd0, busy, done, error, sample_ready}, 64'd0);
    chk("rstmid_words_written", 64'(words_written), 64'd0);
    wb_rst = 1'b1;
    @(posedge wb_clk); #1;
    run_xfer(post_rst, 99);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
